fmac_issue_ctrl: RTL and testbench

- Issue and retire controller for the fused multiply-add datapath, which is a fixed-latency pipeline with no backpressure ending in the rounding stage.
- Accepts FMA requests over a valid/ready handshake and resolves the dynamic rounding mode against the frm CSR.
- Issues requests into the datapath, tracks in-flight tags, captures results and IEEE flags into a result FIFO, and accumulates sticky fflags for the CSR file.
- Guarantees no result is ever lost by credit-based issue throttling.

---
 rtl/fmac_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_fmac_issue_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmac_issue_ctrl.sv
// Issue/retire controller for the fixed-latency FMA datapath: resolves the rounding
// mode, issues under credit control, queues results in order and keeps sticky fflags.
module fmac_issue_ctrl #(
  parameter int PARM_LAT        = 4,
  parameter int PARM_FIFO_DEPTH = 4,
  parameter int PARM_TAG        = 4,
  parameter int PARM_XLEN       = 32,
  parameter int PARM_RM         = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [PARM_RM-1:0]   req_rm_i,
  input  logic [PARM_TAG-1:0]  req_tag_i,
  input  logic [PARM_RM-1:0]   frm_i,
  input  logic                 flush_i,
  output logic                 dp_valid_o,
  output logic [PARM_RM-1:0]   dp_rm_o,
  input  logic [PARM_XLEN-1:0] dp_result_i,
  input  logic [4:0]           dp_flags_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [PARM_XLEN-1:0] resp_data_o,
  output logic [4:0]           resp_flags_o,
  output logic [PARM_TAG-1:0]  resp_tag_o,
  output logic                 resp_err_o,
  output logic [4:0]           fflags_o,
  input  logic                 fflags_clr_i,
  output logic                 busy_o
);
  // state   | meaning
  // S_IDLE  | nothing in flight, FIFO empty
  // S_BUSY  | ops in flight or results queued
  // S_FLUSH | one-cycle kill window, requests blocked
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FLUSH} state_t;

  localparam int AW = $clog2(PARM_FIFO_DEPTH);
  localparam int CW = AW + 1;

  state_t                r_state;
  logic                  r_run;
  logic [PARM_LAT:0]     r_sr_vld;
  logic [PARM_TAG-1:0]   r_sr_tag [PARM_LAT+1];
  logic [PARM_RM-1:0]    r_dp_rm;
  logic [CW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_inflight;
  logic [PARM_XLEN-1:0]  r_mem_data  [PARM_FIFO_DEPTH];
  logic [4:0]            r_mem_flags [PARM_FIFO_DEPTH];
  logic [PARM_TAG-1:0]   r_mem_tag   [PARM_FIFO_DEPTH];
  logic [PARM_FIFO_DEPTH-1:0] r_mem_err;
  logic [4:0]            r_fflags;
  logic                  r_busy;

  logic [PARM_RM-1:0] w_eff_rm;
  logic               w_legal;
  logic [CW-1:0]      w_count;
  logic [CW:0]        w_used;
  logic               w_ready;
  logic               w_acc_legal;
  logic               w_acc_ill;
  logic               w_res_push;
  logic               w_push;
  logic               w_nonempty;
  logic               w_pop;
  logic [AW-1:0]      w_wr_idx;
  logic [AW-1:0]      w_rd_idx;
  logic [CW-1:0]      w_infl_nxt;
  logic [CW-1:0]      w_cnt_nxt;

  assign w_eff_rm   = (req_rm_i == '1) ? frm_i : req_rm_i;
  assign w_legal    = (w_eff_rm <= PARM_RM'(4));
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_used     = {1'b0, w_count} + {1'b0, r_inflight};
  assign w_nonempty = (w_count != '0);

  // Illegal ops skip the datapath, so they wait for an empty pipe to keep response order.
  assign w_ready = r_run && (r_state != S_FLUSH) && !flush_i &&
                   (w_legal ? (w_used < (CW+1)'(PARM_FIFO_DEPTH))
                            : ((r_inflight == '0) && (w_count < CW'(PARM_FIFO_DEPTH))));

  assign w_acc_legal = req_valid_i & w_ready & w_legal;
  assign w_acc_ill   = req_valid_i & w_ready & ~w_legal;
  assign w_res_push  = r_sr_vld[PARM_LAT] & ~flush_i;
  assign w_push      = w_res_push | w_acc_ill;
  assign w_pop       = w_nonempty & resp_ready_i;
  assign w_wr_idx    = r_wr_ptr[AW-1:0];
  assign w_rd_idx    = r_rd_ptr[AW-1:0];
  assign w_infl_nxt  = r_inflight + CW'(w_acc_legal) - CW'(r_sr_vld[PARM_LAT]);
  assign w_cnt_nxt   = w_count + CW'(w_push) - CW'(w_pop);

  assign req_ready_o  = w_ready;
  assign dp_valid_o   = r_sr_vld[0];
  assign dp_rm_o      = r_dp_rm;
  assign resp_valid_o = w_nonempty;
  assign resp_data_o  = w_nonempty ? r_mem_data[w_rd_idx]  : '0;
  assign resp_flags_o = w_nonempty ? r_mem_flags[w_rd_idx] : '0;
  assign resp_tag_o   = w_nonempty ? r_mem_tag[w_rd_idx]   : '0;
  assign resp_err_o   = w_nonempty & r_mem_err[w_rd_idx];
  assign fflags_o     = r_fflags;
  assign busy_o       = r_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_run      <= 1'b0;
      r_sr_vld   <= '0;
      r_dp_rm    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= '0;
      r_mem_err  <= '0;
      r_fflags   <= '0;
      r_busy     <= 1'b0;
      for (int k = 0; k <= PARM_LAT; k++) r_sr_tag[k] <= '0;
      for (int k = 0; k < PARM_FIFO_DEPTH; k++) begin
        r_mem_data[k]  <= '0;
        r_mem_flags[k] <= '0;
        r_mem_tag[k]   <= '0;
      end
    end else begin
      r_run  <= 1'b1;
      r_busy <= (r_inflight != '0) || w_nonempty;

      if (w_res_push) r_fflags <= (fflags_clr_i ? 5'b0 : r_fflags) | dp_flags_i;
      else if (fflags_clr_i) r_fflags <= '0;

      if (flush_i) begin
        r_state    <= S_FLUSH;
        r_sr_vld   <= '0;
        r_inflight <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        r_sr_vld    <= {r_sr_vld[PARM_LAT-1:0], w_acc_legal};
        r_sr_tag[0] <= req_tag_i;
        for (int k = 1; k <= PARM_LAT; k++) r_sr_tag[k] <= r_sr_tag[k-1];
        if (w_acc_legal) r_dp_rm <= w_eff_rm;

        if (w_push) begin
          r_mem_data[w_wr_idx]  <= w_res_push ? dp_result_i : '0;
          r_mem_flags[w_wr_idx] <= w_res_push ? dp_flags_i : '0;
          r_mem_tag[w_wr_idx]   <= w_res_push ? r_sr_tag[PARM_LAT] : req_tag_i;
          r_mem_err[w_wr_idx]   <= ~w_res_push;
          r_wr_ptr              <= r_wr_ptr + CW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + CW'(1);
        r_inflight <= w_infl_nxt;

        if (r_state == S_FLUSH) r_state <= S_IDLE;
        else r_state <= ((w_infl_nxt != '0) || (w_cnt_nxt != '0)) ? S_BUSY : S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fmac_issue_ctrl.sv
// Scoreboard bench for fmac_issue_ctrl: accepted requests queue expected responses,
// a negedge monitor checks issue, credit, response order/latency, busy and fflags.
module tb_fmac_issue_ctrl;
  localparam int LAT = 4, DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_rm = '0, frm = '0;
  logic [3:0]  req_tag = '0;
  logic        flush = 1'b0, clr = 1'b0, resp_ready = 1'b0;
  logic        dp_valid;
  logic [2:0]  dp_rm;
  logic [31:0] dp_result = '0, resp_data;
  logic [4:0]  dp_flags = '0, resp_flags, fflags;
  logic        resp_valid, resp_err, busy;
  logic [3:0]  resp_tag;

  always #5 clk = ~clk;

  fmac_issue_ctrl #(.PARM_LAT(LAT), .PARM_FIFO_DEPTH(DEPTH), .PARM_TAG(4),
                    .PARM_XLEN(32), .PARM_RM(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rm_i(req_rm), .req_tag_i(req_tag), .frm_i(frm), .flush_i(flush),
    .dp_valid_o(dp_valid), .dp_rm_o(dp_rm), .dp_result_i(dp_result), .dp_flags_i(dp_flags),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_flags_o(resp_flags), .resp_tag_o(resp_tag), .resp_err_o(resp_err),
    .fflags_o(fflags), .fflags_clr_i(clr), .busy_o(busy));

  typedef struct {int acc; logic legal; logic [2:0] rm; logic [3:0] tag;
                  logic [31:0] data; logic [4:0] flags;} exp_t;
  typedef struct {int due; logic [31:0] data; logic [4:0] flags; logic live;} dp_t;

  exp_t sb[$];
  dp_t  dq[$];
  int   cyc = 0, errors = 0, checks = 0, n_acc = 0, occ_last = 0;
  logic [4:0]  ff_model = '0;
  logic        rst_prev = 1'b1, flush_prev = 1'b0, last_acc = 1'b0;
  logic [31:0] nxt_data = '0;
  logic [4:0]  nxt_flags = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: returns the scheduled payload on its due cycle, noise otherwise.
  always @(posedge clk) begin
    #1;
    if (dq.size() > 0 && dq[0].due == cyc) begin
      dp_result = dq[0].data;
      dp_flags  = dq[0].flags;
    end else begin
      dp_result = $urandom;
      dp_flags  = 5'($urandom);
    end
  end

  always @(negedge clk) begin
    dp_t  d;
    exp_t e;
    logic dp_live, exp_rdy, exp_dpv, head_rdy, legal_now;
    logic [2:0] erm, eff;
    logic [31:0] pdata;
    logic [4:0]  pflags;
    int occ, infl;
    dp_live = 1'b0;
    d = '{0, '0, '0, 1'b0};
    if (dq.size() > 0 && dq[0].due == cyc) begin
      d = dq.pop_front();
      dp_live = d.live;
    end
    if (!rst_n) begin
      sb.delete();
      foreach (dq[i]) dq[i].live = 1'b0;
      ff_model = '0; occ_last = 0; rst_prev = 1'b1; flush_prev = 1'b0;
    end else begin
      occ = 0; infl = 0;
      foreach (sb[i]) if (sb[i].acc < cyc) begin
        occ++;
        if (sb[i].legal && cyc < sb[i].acc + LAT + 2) infl++;
      end
      eff = (req_rm == 3'b111) ? frm : req_rm;
      legal_now = (eff <= 3'd4);
      exp_rdy = !rst_prev && !flush_prev && !flush &&
                (legal_now ? (occ < DEPTH) : (infl == 0 && occ < DEPTH));
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, occ_last != 0);
      chk("fflags", fflags, ff_model);

      exp_dpv = 1'b0; erm = '0; pdata = '0; pflags = '0;
      foreach (sb[i]) if (sb[i].legal && sb[i].acc == cyc - 1) begin
        exp_dpv = 1'b1; erm = sb[i].rm; pdata = sb[i].data; pflags = sb[i].flags;
      end
      chk("dp_valid", dp_valid, exp_dpv);
      if (exp_dpv) begin
        if (dp_valid) chk("dp_rm", dp_rm, erm);
        dq.push_back('{due: cyc + LAT, data: pdata, flags: pflags, live: 1'b1});
      end

      head_rdy = 1'b0;
      if (occ > 0)
        head_rdy = sb[0].legal ? (cyc >= sb[0].acc + LAT + 2) : (cyc >= sb[0].acc + 1);
      chk("resp_valid", resp_valid, head_rdy);
      if (head_rdy && resp_valid && resp_ready) begin
        e = sb.pop_front();
        chk("resp_tag", resp_tag, e.tag);
        chk("resp_err", resp_err, !e.legal);
        chk("resp_data", resp_data, e.legal ? e.data : 32'h0);
        chk("resp_flags", resp_flags, e.legal ? e.flags : 5'h0);
      end

      if (dp_live && !flush) ff_model = (clr ? 5'h0 : ff_model) | d.flags;
      else if (clr) ff_model = '0;
      if (flush) begin
        sb.delete();
        foreach (dq[i]) dq[i].live = 1'b0;
      end
      occ_last = occ; rst_prev = 1'b0; flush_prev = flush;
    end
  end

  // Record acceptance mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    exp_t e;
    logic [2:0] er;
    #2;
    last_acc = 1'b0;
    if (rst_n && req_valid && req_ready) begin
      er = (req_rm == 3'b111) ? frm : req_rm;
      e.acc = cyc; e.legal = (er <= 3'd4); e.rm = er; e.tag = req_tag;
      e.data = nxt_data; e.flags = nxt_flags;
      sb.push_back(e);
      last_acc = 1'b1;
      n_acc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; flush = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_dp_rm", dp_rm, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_word", {resp_data, resp_flags, resp_tag, resp_err}, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached with %0d pending responses", sb.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int n, tag_ctr;
    logic [4:0] ff_saved;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    resp_ready = 1'b1;

    // single op: rm=000, tag 3, known payload
    req_valid = 1'b1; req_rm = 3'b000; req_tag = 4'd3;
    nxt_data = 32'h3F80_0000; nxt_flags = 5'b00001;
    tick();
    chk("single_accept", last_acc, 1);
    req_valid = 1'b0;
    repeat (LAT + 1) tick();
    chk("single_fflags", fflags, 5'b00001);
    repeat (3) tick();

    // dynamic rm from frm, then an illegal dynamic rm behind an in-flight op
    req_valid = 1'b1; req_rm = 3'b111; frm = 3'b011; req_tag = 4'd1; nxt_flags = 5'b00010;
    tick();
    chk("dyn_accept", last_acc, 1);
    frm = 3'b101; req_tag = 4'd2;
    n = 0;
    do begin tick(); n++; end while (!last_acc && n < 30);
    chk("illegal_wait", n, LAT + 2);
    req_valid = 1'b0; frm = 3'b000;
    repeat (4) tick();

    // credit limit: six back-to-back requests with the consumer stalled
    resp_ready = 1'b0; n_acc = 0; tag_ctr = 0;
    req_valid = 1'b1; req_rm = 3'b000; nxt_flags = '0;
    for (int i = 0; i < 12; i++) begin
      req_tag = 4'(tag_ctr); nxt_data = $urandom; tick();
      if (last_acc) tag_ctr++;
    end
    chk("credit_accepts", n_acc, DEPTH);
    chk("credit_ready", req_ready, 0);
    resp_ready = 1'b1;
    for (int i = 0; i < 40 && n_acc < 6; i++) begin
      req_tag = 4'(tag_ctr); nxt_data = $urandom; tick();
      if (last_acc) tag_ctr++;
    end
    chk("credit_total", n_acc, 6);
    req_valid = 1'b0;
    repeat (10) tick();

    // clear in the same cycle as the second result push
    req_valid = 1'b1; req_tag = 4'd8; nxt_flags = 5'b10000; tick();
    chk("clr_acc0", last_acc, 1);
    req_tag = 4'd9; nxt_flags = 5'b00100; tick();
    chk("clr_acc1", last_acc, 1);
    req_valid = 1'b0;
    repeat (LAT) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_fflags", fflags, 5'b00100);
    repeat (4) tick();

    // flush with three in flight and one queued
    resp_ready = 1'b0; req_valid = 1'b1; nxt_flags = 5'b01000;
    for (int i = 0; i < 4; i++) begin req_tag = 4'(10 + i); tick(); end
    req_valid = 1'b0;
    repeat (2) tick();
    chk("flush_pre_valid", resp_valid, 1);
    ff_saved = fflags;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_resp_valid", resp_valid, 0);
    tick();
    chk("flush_busy", busy, 0);
    repeat (LAT + 2) tick();
    chk("flush_late_valid", resp_valid, 0);
    chk("flush_fflags", fflags, ff_saved);
    resp_ready = 1'b1;

    // asynchronous reset with two ops in flight
    req_valid = 1'b1; nxt_flags = 5'b11111;
    req_tag = 4'd14; tick();
    req_tag = 4'd15; tick();
    do_reset();
    repeat (LAT + 4) tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid  = ($urandom_range(0, 99) < 60);
      req_rm     = ($urandom_range(0, 9) < 8) ? (($urandom_range(0, 5) == 5) ? 3'b111 : 3'($urandom_range(0, 4)))
                                               : 3'($urandom_range(5, 7));
      frm        = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      req_tag    = 4'($urandom);
      nxt_data   = $urandom;
      nxt_flags  = 5'($urandom);
      resp_ready = ($urandom_range(0, 99) < 70);
      flush      = ($urandom_range(0, 99) == 0);
      clr        = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick();
    end

    req_valid = 1'b0; flush = 1'b0; clr = 1'b0; resp_ready = 1'b1;
    repeat (LAT + DEPTH + 6) tick();
    chk("drain_pending", sb.size(), 0);
    chk("drain_valid", resp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
